nn_mlp_pipe: RTL

- Parametrised, pipelined two-layer perceptron node: N_IN inputs, N_HID hidden ReLU neurons, N_OUT outputs.
- Signed two's-complement data and weights.
- Replaces the fixed 4-4-2 node with:
  - valid/ready streaming on input and output;
  - a registered weight bank loaded through its own handshake;
  - saturating ReLU.
- Sits between the feature-fetch stage and the aggregation stage of the accelerator datapath.

---
 rtl/nn_mlp_pipe.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/nn_mlp_pipe.sv
// nn_mlp_pipe: pipelined two-layer perceptron node (N_IN -> N_HID ReLU -> N_OUT).
//
// Three register stages, all advanced by one global enable:
//   S1  r_y : hidden pre-activations y[h] = sum_i x[i]*w1[i][h]   (valid r_v1)
//   S2  r_z : saturating ReLU of y, unsigned HW bits              (valid r_v2)
//   S3  r_out: out[o] = sum_h z[h]*w2[h][o], signed OW bits       (valid r_v3)
// A vector whose handshake completes on edge k is in S1 after k, S2 after k+1
// and S3 (out_valid) after k+2, i.e. it is visible on the third edge counted
// from and including its acceptance edge.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready/x_flat  input vector stream, x[i] = x_flat[i*DW +: DW]
//   wgt_valid/wgt_ready       weight bank load handshake
//   w1_flat                   w1[i][h] at ((i*N_HID)+h)*DW
//   w2_flat                   w2[h][o] at ((h*N_OUT)+o)*DW
//   out_valid/out_ready       output stream handshake
//   out_flat                  out[o] = out_flat[o*OW +: OW], signed
module nn_mlp_pipe #(
  parameter int N_IN  = 4,
  parameter int N_HID = 4,
  parameter int N_OUT = 2,
  parameter int DW    = 5,
  parameter int HW    = 8
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic [N_IN*DW-1:0]                           x_flat,
  input  logic                                         wgt_valid,
  output logic                                         wgt_ready,
  input  logic [N_IN*N_HID*DW-1:0]                     w1_flat,
  input  logic [N_HID*N_OUT*DW-1:0]                    w2_flat,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [N_OUT*(HW+DW+1+$clog2(N_HID))-1:0]     out_flat
);

  localparam int OW = HW + DW + 1 + $clog2(N_HID);
  localparam int YW = 2*DW + $clog2(N_IN);
  localparam logic signed [YW-1:0] Z_MAX = YW'((2**HW) - 1);

  // Weight bank
  logic [N_IN*N_HID*DW-1:0]  r_w1;
  logic [N_HID*N_OUT*DW-1:0] r_w2;

  // Pipeline state
  logic                    r_v1, r_v2, r_v3;
  logic signed [YW-1:0]    r_y [N_HID];
  logic [HW-1:0]           r_z [N_HID];
  logic [N_OUT*OW-1:0]     r_out;

  // Combinational views
  logic                    w_en;
  logic                    w_in_fire;
  logic                    w_wgt_fire;
  logic signed [DW-1:0]    w_x  [N_IN];
  logic signed [DW-1:0]    w_w1 [N_IN*N_HID];
  logic signed [DW-1:0]    w_w2 [N_HID*N_OUT];
  logic signed [YW-1:0]    w_y  [N_HID];
  logic [HW-1:0]           w_z  [N_HID];
  logic signed [OW-1:0]    w_o  [N_OUT];
  logic [N_OUT*OW-1:0]     w_out_flat;

  // The whole pipe moves together; it only stops when a result is parked
  // at the output and the consumer is not taking it.
  assign w_en       = !r_v3 || out_ready;
  // A pending weight load blocks new inputs so the pipe can drain.
  assign in_ready   = w_en && !wgt_valid && !rst;
  // The bank may only change once no vector still depends on it.
  assign wgt_ready  = wgt_valid && !r_v1 && !r_v2 && !r_v3 && !rst;
  assign w_in_fire  = in_valid && in_ready;
  assign w_wgt_fire = wgt_valid && wgt_ready;

  assign out_valid  = r_v3;
  assign out_flat   = r_out;

  // Unpack flat buses into signed element arrays
  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_x
      assign w_x[gi] = x_flat[gi*DW +: DW];
    end
    for (gi = 0; gi < N_IN*N_HID; gi++) begin : g_w1
      assign w_w1[gi] = r_w1[gi*DW +: DW];
    end
    for (gi = 0; gi < N_HID*N_OUT; gi++) begin : g_w2
      assign w_w2[gi] = r_w2[gi*DW +: DW];
    end
  endgenerate

  // S1 hidden MAC: operands are sign-extended to YW before multiplying, so
  // every product and the running sum are exact.
  always_comb begin
    for (int h = 0; h < N_HID; h++) begin
      w_y[h] = '0;
      for (int i = 0; i < N_IN; i++) begin
        w_y[h] = w_y[h] + YW'(w_x[i]) * YW'(w_w1[i*N_HID + h]);
      end
    end
  end

  // S2 saturating ReLU: clamp to [0, 2^HW-1]
  generate
    for (gi = 0; gi < N_HID; gi++) begin : g_relu
      assign w_z[gi] = (r_y[gi] < 0)     ? '0 :
                       (r_y[gi] > Z_MAX) ? '1 :
                       r_y[gi][HW-1:0];
    end
  endgenerate

  // S3 output MAC: z is non-negative, so a zero MSB makes it a valid signed
  // operand; OW is sized so the sum of N_HID products cannot overflow.
  always_comb begin
    for (int o = 0; o < N_OUT; o++) begin
      w_o[o] = '0;
      for (int h = 0; h < N_HID; h++) begin
        w_o[o] = w_o[o] + OW'($signed({1'b0, r_z[h]})) * OW'(w_w2[h*N_OUT + o]);
      end
    end
  end

  generate
    for (gi = 0; gi < N_OUT; gi++) begin : g_opack
      assign w_out_flat[gi*OW +: OW] = w_o[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_w1  <= '0;
      r_w2  <= '0;
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
      r_v3  <= 1'b0;
      r_out <= '0;
      for (int h = 0; h < N_HID; h++) begin
        r_y[h] <= '0;
        r_z[h] <= '0;
      end
    end else begin
      if (w_wgt_fire) begin
        r_w1 <= w1_flat;
        r_w2 <= w2_flat;
      end
      if (w_en) begin
        r_v1 <= w_in_fire;
        r_v2 <= r_v1;
        r_v3 <= r_v2;
        // Data registers only load real vectors; bubbles leave them as is.
        if (w_in_fire) begin
          for (int h = 0; h < N_HID; h++) r_y[h] <= w_y[h];
        end
        if (r_v1) begin
          for (int h = 0; h < N_HID; h++) r_z[h] <= w_z[h];
        end
        if (r_v2) begin
          r_out <= w_out_flat;
        end
      end
    end
  end

endmodule
